// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the scoreboarded register file
package regfile_pkg;
  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_START = 2'b01;
  localparam logic [1:0] PC_SEL_DP = 2'b11;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREG = 16;
  localparam int DEF_NRD = 4;
  localparam int DEF_PC_W = 11;
  localparam int DEF_CNT_W = 2;
  localparam int DEF_BYPASS = 1;
  localparam int SP = 13;
  localparam int LR = 14;
  localparam int PC = 15;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: write, load-tracking, read and PC signals of the register file
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG = DEF_NREG,
  parameter int NRD = DEF_NRD,
  parameter int PC_W = DEF_PC_W
);
  localparam int AW = $clog2(NREG);
  logic w_en1;
  logic [AW-1:0] w_addr1;
  logic [DATA_W-1:0] w_data1;
  logic w_en_ldr;
  logic [AW-1:0] w_addr_ldr;
  logic [DATA_W-1:0] w_data_ldr;
  logic ld_issue;
  logic [AW-1:0] ld_issue_addr;
  logic [NRD-1:0][AW-1:0] rd_addr;
  logic [NRD-1:0][DATA_W-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic load_pc;
  logic [1:0] sel_pc;
  logic [PC_W-1:0] start_pc;
  logic [PC_W-1:0] dp_pc;
  logic [PC_W-1:0] pc_out;
  logic sb_err;
  modport master (
    output w_en1, w_addr1, w_data1, w_en_ldr, w_addr_ldr, w_data_ldr,
    output ld_issue, ld_issue_addr, rd_addr, load_pc, sel_pc, start_pc, dp_pc,
    input rd_data, rd_busy, pc_out, sb_err
  );
  modport slave (
    input w_en1, w_addr1, w_data1, w_en_ldr, w_addr_ldr, w_data_ldr,
    input ld_issue, ld_issue_addr, rd_addr, load_pc, sel_pc, start_pc, dp_pc,
    output rd_data, rd_busy, pc_out, sb_err
  );
endinterface

// File: rtl/regfile_sb_counter.sv
// sb_counter: saturating up/down pending-load counter with an over/underflow pulse
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic [CNT_W-1:0] cnt,
  output logic err
);
  logic up, dn;
  assign up = inc && !dec;
  assign dn = dec && !inc;
  assign err = (up && &cnt) || (dn && cnt == '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (up && !(&cnt)) cnt <= cnt + 1'b1;
    else if (dn && |cnt) cnt <= cnt - 1'b1;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with ALU/load/PC write paths, optional bypass and load scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG = DEF_NREG,
  parameter int NRD = DEF_NRD,
  parameter int PC_W = DEF_PC_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int BYPASS = DEF_BYPASS
) (
  input logic clk,
  input logic rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int PCR = NREG - 1;
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0][DATA_W-1:0] wd;
  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0] we, byp, err;
  logic [PC_W-1:0] pc_nxt;
  assign bus.pc_out = regs[PCR][PC_W-1:0];
  assign pc_nxt = bus.sel_pc == PC_SEL_START ? bus.start_pc :
                  bus.sel_pc == PC_SEL_DP ? bus.dp_pc : bus.pc_out + 1'b1;
  genvar r;
  for (r = 0; r < NREG; r++) begin : g_reg
    logic pc_hit, ldr_hit, alu_hit;
    assign pc_hit = bus.load_pc && (r == PCR);
    assign ldr_hit = bus.w_en_ldr && bus.w_addr_ldr == AW'(r);
    assign alu_hit = bus.w_en1 && bus.w_addr1 == AW'(r);
    assign we[r] = pc_hit || ldr_hit || alu_hit;
    // PC updates never forward; a dropped ALU write under load_pc must not forward either
    assign byp[r] = !pc_hit && (ldr_hit || alu_hit);
    assign wd[r] = pc_hit ? DATA_W'(pc_nxt) : ldr_hit ? bus.w_data_ldr : bus.w_data1;
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(bus.ld_issue && bus.ld_issue_addr == AW'(r)),
      .dec(ldr_hit),
      .cnt(cnt[r]),
      .err(err[r])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      bus.sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) if (we[i]) regs[i] <= wd[i];
      bus.sb_err <= bus.sb_err | (|err);
    end
  always_comb
    for (int i = 0; i < NRD; i++) begin
      bus.rd_data[i] = (BYPASS != 0 && !rst && byp[bus.rd_addr[i]]) ? wd[bus.rd_addr[i]] : regs[bus.rd_addr[i]];
      bus.rd_busy[i] = |cnt[bus.rd_addr[i]];
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard-queue bench for regfile_sb (bypass and no-bypass builds)
module tb_regfile_sb;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_sb_if bus ();
  regfile_sb_if bus0 ();
  regfile_sb dut (.clk(clk), .rst(rst), .bus(bus));
  regfile_sb #(.BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.w_en1 = 0; bus.w_en_ldr = 0; bus.ld_issue = 0; bus.load_pc = 0;
    bus0.w_en1 = 0; bus0.w_en_ldr = 0; bus0.ld_issue = 0; bus0.load_pc = 0;
  endtask

  task automatic test_reset();
    bus.rd_addr[0] = 4'd0; bus.rd_addr[1] = 4'd3; bus.rd_addr[2] = 4'd15; bus.rd_addr[3] = 4'd1;
    bus.w_en1 = 1; bus.w_addr1 = 4'd3; bus.w_data1 = 32'h55;
    bus.ld_issue = 1; bus.ld_issue_addr = 4'd3;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_data[1]) !== e) begin bad++; $display("FAIL rst_rd got=%h exp=%h", bus.rd_data[1], e); end
    e = exp_q.pop_front(); total++; if (32'(bus.pc_out) !== e) begin bad++; $display("FAIL rst_pc got=%h exp=%h", bus.pc_out, e); end
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy) !== e) begin bad++; $display("FAIL rst_busy got=%h exp=%h", bus.rd_busy, e); end
    e = exp_q.pop_front(); total++; if (32'(bus.sb_err) !== e) begin bad++; $display("FAIL rst_err got=%h exp=%h", bus.sb_err, e); end
    cyc(); rst = 0; idle();
    exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_data[1]) !== e) begin bad++; $display("FAIL rst_r3_lost got=%h exp=%h", bus.rd_data[1], e); end
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy) !== e) begin bad++; $display("FAIL rst_busy2 got=%h exp=%h", bus.rd_busy, e); end
    cyc(); bus.ld_issue = 1; bus.ld_issue_addr = 4'd9;
    cyc(); idle(); bus.rd_addr[0] = 4'd9; bus.rd_addr[1] = 4'd7;
    exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[0]) !== e) begin bad++; $display("FAIL r9_busy got=%h exp=%h", bus.rd_busy[0], e); end
    cyc(); bus.w_en1 = 1; bus.w_addr1 = 4'd7; bus.w_data1 = 32'h77; rst = 1;
    exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_data[1]) !== e) begin bad++; $display("FAIL midrst_rd got=%h exp=%h", bus.rd_data[1], e); end
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[0]) !== e) begin bad++; $display("FAIL midrst_busy got=%h exp=%h", bus.rd_busy[0], e); end
    cyc(); rst = 0; idle();
    exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_data[1]) !== e) begin bad++; $display("FAIL r7_lost got=%h exp=%h", bus.rd_data[1], e); end
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[0]) !== e) begin bad++; $display("FAIL r9_clear got=%h exp=%h", bus.rd_busy[0], e); end
  endtask

  task automatic test_write_priority();
    bus.rd_addr[0] = 4'd3; bus.rd_addr[1] = 4'd4; bus.rd_addr[2] = 4'd8; bus.rd_addr[3] = 4'd0;
    cyc(); bus.ld_issue = 1; bus.ld_issue_addr = 4'd3;
    cyc(); bus.ld_issue_addr = 4'd8;
    cyc(); idle();
    bus.w_en1 = 1; bus.w_addr1 = 4'd3; bus.w_data1 = 32'h11;
    bus.w_en_ldr = 1; bus.w_addr_ldr = 4'd3; bus.w_data_ldr = 32'h22;
    exp_q.push_back(32'h22);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (bus.rd_data[0] !== e) begin bad++; $display("FAIL prio_byp got=%h exp=%h", bus.rd_data[0], e); end
    cyc(); bus.w_addr1 = 4'd4; bus.w_data1 = 32'h44; bus.w_addr_ldr = 4'd8; bus.w_data_ldr = 32'h88;
    exp_q.push_back(32'h22); exp_q.push_back(32'h44); exp_q.push_back(32'h88);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (bus.rd_data[0] !== e) begin bad++; $display("FAIL prio_r3 got=%h exp=%h", bus.rd_data[0], e); end
    e = exp_q.pop_front(); total++; if (bus.rd_data[1] !== e) begin bad++; $display("FAIL dual_r4_byp got=%h exp=%h", bus.rd_data[1], e); end
    e = exp_q.pop_front(); total++; if (bus.rd_data[2] !== e) begin bad++; $display("FAIL dual_r8_byp got=%h exp=%h", bus.rd_data[2], e); end
    cyc(); idle();
    exp_q.push_back(32'h44); exp_q.push_back(32'h88); exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (bus.rd_data[1] !== e) begin bad++; $display("FAIL dual_r4 got=%h exp=%h", bus.rd_data[1], e); end
    e = exp_q.pop_front(); total++; if (bus.rd_data[2] !== e) begin bad++; $display("FAIL dual_r8 got=%h exp=%h", bus.rd_data[2], e); end
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy) !== e) begin bad++; $display("FAIL prio_busy got=%h exp=%h", bus.rd_busy, e); end
    e = exp_q.pop_front(); total++; if (32'(bus.sb_err) !== e) begin bad++; $display("FAIL prio_err got=%h exp=%h", bus.sb_err, e); end
  endtask

  task automatic test_bypass();
    cyc(); bus.rd_addr[0] = 4'd5; bus0.rd_addr[0] = 4'd5;
    bus.w_en1 = 1; bus.w_addr1 = 4'd5; bus.w_data1 = 32'hDEADBEEF;
    bus0.w_en1 = 1; bus0.w_addr1 = 4'd5; bus0.w_data1 = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (bus.rd_data[0] !== e) begin bad++; $display("FAIL byp1 got=%h exp=%h", bus.rd_data[0], e); end
    e = exp_q.pop_front(); total++; if (bus0.rd_data[0] !== e) begin bad++; $display("FAIL byp0_old got=%h exp=%h", bus0.rd_data[0], e); end
    cyc(); idle();
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (bus0.rd_data[0] !== e) begin bad++; $display("FAIL byp0_new got=%h exp=%h", bus0.rd_data[0], e); end
  endtask

  task automatic test_pc();
    bus.rd_addr[3] = 4'(PC);
    cyc(); bus.load_pc = 1; bus.sel_pc = PC_SEL_START; bus.start_pc = 11'h7FE;
    exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.pc_out) !== e) begin bad++; $display("FAIL pc_lat got=%h exp=%h", bus.pc_out, e); end
    e = exp_q.pop_front(); total++; if (bus.rd_data[3] !== e) begin bad++; $display("FAIL pc_nobyp got=%h exp=%h", bus.rd_data[3], e); end
    cyc(); bus.sel_pc = PC_SEL_INC;
    exp_q.push_back(32'h7FE);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.pc_out) !== e) begin bad++; $display("FAIL pc_start got=%h exp=%h", bus.pc_out, e); end
    cyc();
    exp_q.push_back(32'h7FF);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.pc_out) !== e) begin bad++; $display("FAIL pc_inc got=%h exp=%h", bus.pc_out, e); end
    cyc(); bus.sel_pc = PC_SEL_DP; bus.dp_pc = 11'h123;
    bus.w_en1 = 1; bus.w_addr1 = 4'(PC); bus.w_data1 = 32'hFFFFFFFF;
    exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.pc_out) !== e) begin bad++; $display("FAIL pc_wrap got=%h exp=%h", bus.pc_out, e); end
    e = exp_q.pop_front(); total++; if (bus.rd_data[3] !== e) begin bad++; $display("FAIL pc_alu_nobyp got=%h exp=%h", bus.rd_data[3], e); end
    cyc(); idle();
    exp_q.push_back(32'h123); exp_q.push_back(32'h123);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.pc_out) !== e) begin bad++; $display("FAIL pc_dp_wins got=%h exp=%h", bus.pc_out, e); end
    e = exp_q.pop_front(); total++; if (bus.rd_data[3] !== e) begin bad++; $display("FAIL pc_zext got=%h exp=%h", bus.rd_data[3], e); end
    cyc(); bus.w_en1 = 1; bus.w_addr1 = 4'(PC); bus.w_data1 = 32'h456;
    exp_q.push_back(32'h456);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (bus.rd_data[3] !== e) begin bad++; $display("FAIL pc_indirect_byp got=%h exp=%h", bus.rd_data[3], e); end
    cyc(); idle(); bus.load_pc = 1; bus.sel_pc = 2'b10;
    exp_q.push_back(32'h456);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.pc_out) !== e) begin bad++; $display("FAIL pc_indirect got=%h exp=%h", bus.pc_out, e); end
    cyc(); idle();
    exp_q.push_back(32'h457);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.pc_out) !== e) begin bad++; $display("FAIL pc_sel10 got=%h exp=%h", bus.pc_out, e); end
  endtask

  task automatic test_scoreboard();
    bus.rd_addr[0] = 4'd2; bus.rd_addr[1] = 4'd10;
    cyc(); bus.ld_issue = 1; bus.ld_issue_addr = 4'd2;
    exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[0]) !== e) begin bad++; $display("FAIL sb_lat got=%h exp=%h", bus.rd_busy[0], e); end
    cyc();
    exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[0]) !== e) begin bad++; $display("FAIL sb_busy got=%h exp=%h", bus.rd_busy[0], e); end
    cyc(); idle(); bus.w_en_ldr = 1; bus.w_addr_ldr = 4'd2; bus.w_data_ldr = 32'h2A;
    cyc(); bus.w_data_ldr = 32'h2B;
    exp_q.push_back(1); exp_q.push_back(32'h2B);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[0]) !== e) begin bad++; $display("FAIL sb_one_left got=%h exp=%h", bus.rd_busy[0], e); end
    e = exp_q.pop_front(); total++; if (bus.rd_data[0] !== e) begin bad++; $display("FAIL sb_ret_byp got=%h exp=%h", bus.rd_data[0], e); end
    cyc(); idle();
    exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[0]) !== e) begin bad++; $display("FAIL sb_clear got=%h exp=%h", bus.rd_busy[0], e); end
    cyc(); bus.ld_issue = 1; bus.ld_issue_addr = 4'd2;
    cyc(); bus.w_en_ldr = 1; bus.w_addr_ldr = 4'd2; bus.w_data_ldr = 32'h2C;
    cyc(); idle(); bus.w_en_ldr = 1; bus.w_addr_ldr = 4'd2; bus.w_data_ldr = 32'h2D;
    exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[0]) !== e) begin bad++; $display("FAIL sb_same_cyc got=%h exp=%h", bus.rd_busy[0], e); end
    cyc(); idle();
    exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[0]) !== e) begin bad++; $display("FAIL sb_same_done got=%h exp=%h", bus.rd_busy[0], e); end
    e = exp_q.pop_front(); total++; if (32'(bus.sb_err) !== e) begin bad++; $display("FAIL sb_noerr got=%h exp=%h", bus.sb_err, e); end
    cyc(); bus.ld_issue = 1; bus.ld_issue_addr = 4'd10;
    cyc(); idle(); bus.w_en1 = 1; bus.w_addr1 = 4'd10; bus.w_data1 = 32'hA;
    cyc(); idle();
    exp_q.push_back(32'hA); exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (bus.rd_data[1] !== e) begin bad++; $display("FAIL alu_pend_data got=%h exp=%h", bus.rd_data[1], e); end
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[1]) !== e) begin bad++; $display("FAIL alu_pend_busy got=%h exp=%h", bus.rd_busy[1], e); end
    cyc(); bus.w_en_ldr = 1; bus.w_addr_ldr = 4'd10; bus.w_data_ldr = 32'hB;
    cyc(); idle();
    exp_q.push_back(0); exp_q.push_back(32'hB);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[1]) !== e) begin bad++; $display("FAIL alu_pend_ret got=%h exp=%h", bus.rd_busy[1], e); end
    e = exp_q.pop_front(); total++; if (bus.rd_data[1] !== e) begin bad++; $display("FAIL ldr_data got=%h exp=%h", bus.rd_data[1], e); end
  endtask

  task automatic test_errors();
    bus.rd_addr[0] = 4'd6; bus.rd_addr[1] = 4'd11;
    cyc(); bus.ld_issue = 1; bus.ld_issue_addr = 4'd6;
    cyc();
    cyc();
    cyc(); idle();
    exp_q.push_back(0); exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.sb_err) !== e) begin bad++; $display("FAIL ovf_pre got=%h exp=%h", bus.sb_err, e); end
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[0]) !== e) begin bad++; $display("FAIL ovf_busy got=%h exp=%h", bus.rd_busy[0], e); end
    cyc(); bus.ld_issue = 1; bus.ld_issue_addr = 4'd6;
    cyc(); idle();
    exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.sb_err) !== e) begin bad++; $display("FAIL ovf_err got=%h exp=%h", bus.sb_err, e); end
    cyc(); bus.w_en_ldr = 1; bus.w_addr_ldr = 4'd6; bus.w_data_ldr = 32'h6;
    cyc();
    cyc(); idle();
    exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[0]) !== e) begin bad++; $display("FAIL ovf_sat got=%h exp=%h", bus.rd_busy[0], e); end
    cyc(); bus.w_en_ldr = 1; bus.w_addr_ldr = 4'd6;
    cyc(); idle();
    cyc(); cyc();
    exp_q.push_back(0); exp_q.push_back(1);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy[0]) !== e) begin bad++; $display("FAIL ovf_drain got=%h exp=%h", bus.rd_busy[0], e); end
    e = exp_q.pop_front(); total++; if (32'(bus.sb_err) !== e) begin bad++; $display("FAIL err_sticky got=%h exp=%h", bus.sb_err, e); end
    cyc(); rst = 1;
    exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.sb_err) !== e) begin bad++; $display("FAIL err_rst got=%h exp=%h", bus.sb_err, e); end
    cyc(); rst = 0;
    cyc(); bus.w_en_ldr = 1; bus.w_addr_ldr = 4'd11; bus.w_data_ldr = 32'hBB;
    exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.sb_err) !== e) begin bad++; $display("FAIL unf_pre got=%h exp=%h", bus.sb_err, e); end
    cyc(); idle();
    exp_q.push_back(1); exp_q.push_back(32'hBB); exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front(); total++; if (32'(bus.sb_err) !== e) begin bad++; $display("FAIL unf_err got=%h exp=%h", bus.sb_err, e); end
    e = exp_q.pop_front(); total++; if (bus.rd_data[1] !== e) begin bad++; $display("FAIL unf_data got=%h exp=%h", bus.rd_data[1], e); end
    e = exp_q.pop_front(); total++; if (32'(bus.rd_busy) !== e) begin bad++; $display("FAIL unf_busy got=%h exp=%h", bus.rd_busy, e); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      exp_q.push_back(1);
      @(negedge clk);
      e = exp_q.pop_front(); total++; if (32'(bus.sb_err) !== e) begin bad++; $display("FAIL unf_sticky%0d got=%h exp=%h", i, bus.sb_err, e); end
    end
  endtask

  initial begin
    bus.w_addr1 = '0; bus.w_data1 = '0; bus.w_addr_ldr = '0; bus.w_data_ldr = '0;
    bus.ld_issue_addr = '0; bus.rd_addr = '0; bus.sel_pc = '0; bus.start_pc = '0; bus.dp_pc = '0;
    bus0.w_addr1 = '0; bus0.w_data1 = '0; bus0.w_addr_ldr = '0; bus0.w_data_ldr = '0;
    bus0.ld_issue_addr = '0; bus0.rd_addr = '0; bus0.sel_pc = '0; bus0.start_pc = '0; bus0.dp_pc = '0;
    idle();
    test_reset();
    test_write_priority();
    test_bypass();
    test_pc();
    test_scoreboard();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
